// File: rtl/cfg_reg_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto the single-ported
// config register file. Optional WAIT timeout is built when CFG_ARB_TIMEOUT_EN is defined.
module cfg_reg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_err,
  output logic [ADDR_WIDTH-1:0]              reg_addr,
  output logic [DATA_WIDTH-1:0]              reg_wdata,
  output logic [DATA_WIDTH/8-1:0]            reg_wstrb,
  output logic                               reg_write,
  output logic                               reg_read,
  input  logic [DATA_WIDTH-1:0]              reg_rdata,
  input  logic                               reg_ready,
  output logic                               busy,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic [1:0]                         o_dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = DATA_WIDTH / 8;

  // Handshake: a requester holds req_valid and its fields until req_ready (IDLE only);
  // the transaction completes with a one-cycle rsp_valid pulse to the granted requester.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state, w_next;
  logic [IDW-1:0]        r_last, r_grant, w_gnt, w_cand;
  logic                  w_any;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr, w_sel_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_sel_wdata, r_rsp_data;
  logic [SW-1:0]         r_wstrb, w_sel_wstrb;
  logic                  w_sel_write;

  // Search starts one past the last served requester, wrapping modulo NUM_REQ.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = r_last;
    w_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDW'((int'(r_last) + i) % NUM_REQ);
      if (!w_any && req_valid[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_wstrb = req_wstrb[i*SW +: SW];
        w_sel_write = req_write[i];
      end
    end
  end

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_timeout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    reg_write = 1'b0;
    reg_read  = 1'b0;
    busy      = 1'b1;
`ifdef CFG_ARB_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // Acceptance is combinational, so keep it quiet while reset is held.
        if (w_any && !reset) begin
          req_ready[w_gnt] = 1'b1;
          w_next           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        reg_write = r_write;
        reg_read  = !r_write;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (reg_ready) begin
          w_next = S_RESP;
        end
`ifdef CFG_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          w_next    = S_RESP;
          w_timeout = 1'b1;
        end
`endif
      end
      S_RESP: begin
        rsp_valid[r_grant] = 1'b1;
        w_next             = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= IDW'(NUM_REQ - 1);
      r_grant    <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rsp_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant <= w_gnt;
        r_write <= w_sel_write;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_wstrb <= w_sel_wstrb;
      end
      if (r_state == S_WAIT && reg_ready) begin
        r_rsp_data <= r_write ? '0 : reg_rdata;
      end
`ifdef CFG_ARB_TIMEOUT_EN
      else if (w_timeout) begin
        r_rsp_data <= '0;
      end
`endif
      if (r_state == S_RESP) begin
        r_last <= r_grant;
      end
    end
  end

`ifdef CFG_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_WAIT && reg_ready) r_err <= 1'b0;
      else if (w_timeout)                 r_err <= 1'b1;
    end
  end
  assign rsp_err = r_err;
`else
  // Without the timeout a response can never be an error; the comparison is constant false.
  assign rsp_err = (TIMEOUT_CYCLES < 0);
`endif

  assign rsp_rdata   = r_rsp_data;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_wstrb   = r_wstrb;
  assign grant_id    = r_grant;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Self-checking bench for cfg_reg_arbiter: register-file model, scoreboard queue
// of {id, err, rdata}, and one task per scenario.
module tb_cfg_reg_arbiter;

  localparam int NR   = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TO   = 6;
  localparam int MAXW = 200;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_wstrb;
  logic [DW-1:0]     rsp_rdata, reg_wdata, reg_rdata;
  logic              rsp_err, reg_write, reg_read, reg_ready, busy;
  logic [AW-1:0]     reg_addr;
  logic [SW-1:0]     reg_wstrb;
  logic [0:0]        grant_id;
  logic [1:0]        o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  cfg_reg_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_write(reg_write), .reg_read(reg_read), .reg_rdata(reg_rdata),
    .reg_ready(reg_ready), .busy(busy), .grant_id(grant_id),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register-file model ----------------
  logic [DW-1:0] mem [0:31];
  int            lat = 0;
  bit            hold_low = 1'b0;
  bit            pending = 1'b0;
  int            pcnt = 0;
  logic          p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    reg_ready = 1'b0;
    reg_rdata = '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      reg_ready = 1'b0;
      pending   = 1'b0;
    end else begin
      reg_ready = 1'b0;
      if (pending) begin
        if (pcnt > 0) pcnt--;
        else if (!hold_low) begin
          reg_ready = 1'b1;
          pending   = 1'b0;
          if (p_wr) begin
            reg_rdata = 32'hDEAD_BEEF;
            for (int b = 0; b < SW; b++)
              if (p_wstrb[b]) mem[p_addr][b*8 +: 8] = p_wdata[b*8 +: 8];
          end else begin
            reg_rdata = mem[p_addr];
          end
        end
      end
      if (reg_write || reg_read) begin
        pending = 1'b1;
        pcnt    = lat;
        p_wr    = reg_write;
        p_addr  = reg_addr;
        p_wdata = reg_wdata;
        p_wstrb = reg_wstrb;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [35:0] e;
    logic [2:0]  id_act;
    if (!reset && rsp_valid !== '0) begin
      checks++;
      case (rsp_valid)
        2'b01:   id_act = 3'd0;
        2'b10:   id_act = 3'd1;
        default: id_act = 3'd7;
      endcase
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected rsp_valid=%b rdata=%h required no response", rsp_valid, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({id_act, rsp_err, rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp_compare id=%0d err=%b rdata=%h required id=%0d err=%b rdata=%h",
                   id_act, rsp_err, rsp_rdata, e[35:33], e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input int id, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input bit push, input logic [DW-1:0] exp_d);
    int n;
    bit got;
    @(negedge clk);
    req_write[id]           = wr;
    req_addr[id*AW +: AW]   = a;
    req_wdata[id*DW +: DW]  = d;
    req_wstrb[id*SW +: SW]  = s;
    req_valid[id]           = 1'b1;
    if (push) exp_q.push_back({3'(id), 1'b0, exp_d});
    got = 1'b0;
    n   = 0;
    while (!got && n < MAXW) begin
      #1;
      if (req_ready[id] === 1'b1) got = 1'b1;
      else begin
        if (busy === 1'b1) begin
          checks++;
          if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL ready_while_busy id=%0d req_ready=%b required 00", id, req_ready);
          end
        end
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout id=%0d req_ready=%b required bit set", id, req_ready);
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < MAXW) begin
      if (rsp_valid[id] === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout id=%0d rsp_valid=%b required bit set", id, rsp_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_ready got=%b required 00", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, reg_write, reg_read, busy, grant_id, o_dbg_state} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required 0", {rsp_valid, rsp_err, reg_write, reg_read, busy, grant_id, o_dbg_state});
    end
    checks++;
    if ({rsp_rdata, reg_addr, reg_wdata, reg_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h wstrb=%h required 0", rsp_rdata, reg_addr, reg_wdata, reg_wstrb);
    end
  endtask

  task automatic test_write_read();
    exp_q.push_back({3'd0, 1'b0, 32'h0});
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0 +: AW]  = 5'd2;
    req_wdata[0 +: DW] = 32'h0000_00AA;
    req_wstrb[0 +: SW] = 4'hF;
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_accept req_ready=%b required 01", req_ready); end
    @(posedge clk);
    @(negedge clk);  // cycle 1
    req_valid[0] = 1'b0;
    checks++;
    if ({reg_write, reg_read} !== 2'b10) begin errors++; $display("FAIL wr_strobe_c1 write/read=%b required 10", {reg_write, reg_read}); end
    checks++;
    if (reg_addr !== 5'd2 || reg_wdata !== 32'hAA || reg_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wr_fields addr=%h wdata=%h wstrb=%h required 02/000000aa/f", reg_addr, reg_wdata, reg_wstrb);
    end
    checks++;
    if (busy !== 1'b1 || grant_id !== 1'b0 || o_dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL wr_issue_state busy=%b grant=%b state=%0d required 1/0/1", busy, grant_id, o_dbg_state);
    end
    @(negedge clk);  // cycle 2
    checks++;
    if ({reg_write, reg_read} !== 2'b00 || o_dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL wr_strobe_c2 write/read=%b state=%0d required 00/2", {reg_write, reg_read}, o_dbg_state);
    end
    @(negedge clk);  // cycle 3
    checks++;
    if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_rsp_c3 rsp_valid=%b required 01", rsp_valid); end
    @(negedge clk);  // cycle 4
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle_c4 rsp_valid=%b busy=%b required 00/0", rsp_valid, busy);
    end
    issue(0, 1'b0, 5'd2, '0, '0, 1'b1, 32'h0000_00AA);
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({3'd0, 1'b0, 32'h0});
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0 +: AW]  = 5'd7;
    req_wdata[0 +: DW] = 32'h0000_0011;
    req_wstrb[0 +: SW] = 4'hF;
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_accept0 req_ready=%b required 01", req_ready); end
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid[0] = 1'b0;
        req_write[1] = 1'b0;
        req_addr[AW +: AW] = 5'd7;
        req_valid[1] = 1'b1;
        exp_q.push_back({3'd1, 1'b0, 32'h0000_0011});
      end
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL b2b_early_accept cycle=%0d req_ready=%b required 00", c, req_ready); end
    end
    @(negedge clk);  // cycle 4
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_accept_c4 req_ready=%b required 10", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    for (int n = 0; n < MAXW && exp_q.size() != 0; n++) @(negedge clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    exp_q.push_back({3'd0, 1'b0, 32'h0000_00AA});
    exp_q.push_back({3'd1, 1'b0, 32'h0000_0011});
    exp_q.push_back({3'd0, 1'b0, 32'h0000_00AA});
    exp_q.push_back({3'd1, 1'b0, 32'h0000_0011});
    fork
      begin repeat (2) issue(0, 1'b0, 5'd2, '0, '0, 1'b0, '0); end
      begin repeat (2) issue(1, 1'b0, 5'd7, '0, '0, 1'b0, '0); end
    join
  endtask

  task automatic test_busy_block();
    lat = 3;
    exp_q.push_back({3'd1, 1'b0, 32'h0});
    exp_q.push_back({3'd0, 1'b0, 32'h0000_00AA});
    fork
      issue(1, 1'b0, 5'd0, '0, '0, 1'b0, '0);
      begin
        int n = 0;
        while (o_dbg_state !== 2'd2 && n < 50) begin @(negedge clk); n++; end
        issue(0, 1'b0, 5'd2, '0, '0, 1'b0, '0);
      end
    join
    lat = 0;
  endtask

  task automatic test_partial_write();
    issue(0, 1'b1, 5'd5, 32'h1234_5678, 4'h2, 1'b1, 32'h0);
    issue(0, 1'b0, 5'd5, '0, '0, 1'b1, 32'h0000_5600);
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 4;
    @(negedge clk);
    req_write[1] = 1'b0;
    req_addr[AW +: AW] = 5'd2;
    req_valid[1] = 1'b1;
    n = 0;
    while (o_dbg_state !== 2'd2 && n < 50) begin
      @(negedge clk);
      if (busy === 1'b1) req_valid[1] = 1'b0;
      n++;
    end
    checks++;
    if (o_dbg_state !== 2'd2) begin errors++; $display("FAIL rmid_reach_wait state=%0d required 2", o_dbg_state); end
    req_valid[1] = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, reg_write, reg_read, busy, grant_id, o_dbg_state} !== 11'b0) begin
      errors++;
      $display("FAIL rmid_ctrl got=%b required 0", {req_ready, rsp_valid, rsp_err, reg_write, reg_read, busy, grant_id, o_dbg_state});
    end
    checks++;
    if ({rsp_rdata, reg_addr, reg_wdata, reg_wstrb} !== '0) begin
      errors++;
      $display("FAIL rmid_data rdata=%h addr=%h wdata=%h wstrb=%h required 0", rsp_rdata, reg_addr, reg_wdata, reg_wstrb);
    end
    @(negedge clk);
    reset = 1'b0;
    lat   = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rmid_dropped cycle=%0d rsp_valid=%b required 00", c, rsp_valid); end
    end
    issue(0, 1'b0, 5'd5, '0, '0, 1'b1, 32'h0000_5600);
  endtask

`ifdef CFG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    hold_low = 1'b1;
    exp_q.push_back({3'd0, 1'b1, 32'h0});
    @(negedge clk);
    req_write[0] = 1'b0;
    req_addr[0 +: AW] = 5'd2;
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL to_accept req_ready=%b required 01", req_ready); end
    @(posedge clk);
    k = 0;
    while (k < MAXW) begin
      @(negedge clk);
      k++;
      if (k == 1) req_valid[0] = 1'b0;
      if (rsp_valid[0] === 1'b1) break;
    end
    checks++;
    if (k != TO + 3) begin errors++; $display("FAIL to_latency cycle=%0d required %0d", k, TO + 3); end
    hold_low = 1'b0;
    do_reset();
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_round_robin();
    test_busy_block();
    test_partial_write();
    test_reset_mid();
`ifdef CFG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    for (int n = 0; n < MAXW && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_reg_arbiter.md
# cfg_reg_arbiter

Shares the single-ported configuration register file between `NUM_REQ` requesters, such as the host bus bridge and the layer sequencer. It performs round-robin arbitration, issues exactly one single-cycle read or write strobe per transaction, and waits for the register file's ready pulse. It then returns a one-cycle response to the granted requester. It sits directly in front of the register file and is the only block that drives that file's access port.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `ADDR_WIDTH`, default 5: register address width.
- `DATA_WIDTH`, default 32: register data width; a multiple of 8.
- `TIMEOUT_CYCLES`, default 15: maximum number of WAIT cycles before the arbiter aborts. Used only when `CFG_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened; requester i owns slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  flattened, same slicing rule.
- `req_wstrb`  in  NUM_REQ*DATA_WIDTH/8  flattened byte strobes.
- `req_ready`  out  NUM_REQ  acceptance; at most one bit high per cycle.
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `rsp_rdata`  out  DATA_WIDTH  shared response data; valid only while some `rsp_valid` bit is high.
- `rsp_err`  out  1  timeout flag; qualified by `rsp_valid`.
- `reg_addr`, `reg_wdata`, `reg_wstrb`  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  register-file command fields.
- `reg_write`, `reg_read`  out  1 each  single-cycle command strobes.
- `reg_rdata`  in  DATA_WIDTH  register-file read data.
- `reg_ready`  in  1  register-file completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or most recent grant.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:** if any `req_valid` bit is high, grant the first requester at or after `last_grant+1` (modulo `NUM_REQ`).
  - `req_ready[g]` is combinational in IDLE.
  - On the same edge the arbiter latches addr/wdata/wstrb/write from requester g, loads `grant_id <= g`, and moves to ISSUE.
- **ISSUE:** drive `reg_write` or `reg_read` high for exactly one cycle, with the latched fields on `reg_addr`/`reg_wdata`/`reg_wstrb`; then go to WAIT.
  - `reg_addr`, `reg_wdata` and `reg_wstrb` hold their values until the next ISSUE.
- **WAIT:** stay until `reg_ready` = 1.
  - For a read, capture `reg_rdata` on that edge. For a write, load 0 into the response register.
  - Then go to RESP.
- **RESP:** `rsp_valid[grant_id]` = 1 for one cycle, with `rsp_rdata` driven from the response register. Update `last_grant <= grant_id` and return to IDLE.
- Requester rules:
  - Hold `req_valid` and its fields stable until `req_ready`.
  - Keep at most one transaction outstanding, and do not reassert `req_valid` before the matching `rsp_valid`.
- Fairness: a continuously requesting requester waits at most `NUM_REQ-1` transactions.
- `reg_ready` arriving in IDLE, ISSUE or RESP is ignored.
- `req_valid` bits outside IDLE are ignored; no request is accepted while busy.

## Timing
- Reset (asynchronous):
  - State returns to IDLE.
  - All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, all `reg_*` outputs, `busy`, `grant_id`.
  - `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first.
  - A transaction in flight is dropped with no response.
- Acceptance edge = cycle 0. `reg_read`/`reg_write` is high in cycle 1.
- The register file pulses `reg_ready` in cycle 2, so `rsp_valid` is high in cycle 3.
- Minimum cost is 4 cycles per transaction; the next acceptance can happen no earlier than cycle 4.

## Configuration
- `CFG_ARB_TIMEOUT_EN` defined:
  - A WAIT counter, cleared on entry, increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `reg_ready`, move to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - `rsp_err` = 0 for normal completions.
- `CFG_ARB_TIMEOUT_EN` undefined:
  - No counter is built; WAIT lasts indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- Reset release, then requester 0 writes addr 2, data 0x0000_00AA, wstrb 0xF → `reg_write` high for one cycle (cycle 1) and `rsp_valid[0]` in cycle 3. A subsequent read of addr 2 returns 0xAA.
- Both requesters raise `req_valid` in the same cycle after reset → requester 0 granted first, then requester 1. Under continuous requests the grants alternate 0,1,0,1.
- Requester 1 reads addr 0 while requester 0 asserts `req_valid` during WAIT → requester 0 is not accepted until IDLE, and `req_ready[0]` is never high while `busy` = 1.
- Partial write with wstrb 0x2 and data 0x1234_5678 to addr 5 (previously 0) → read of addr 5 returns 0x0000_5600.
- Assert `reset` during WAIT → all outputs 0 in the same cycle and no `rsp_valid` appears; the next request is served normally.
- With `CFG_ARB_TIMEOUT_EN` and a bench-held-low `reg_ready` → `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` = 0 exactly `TIMEOUT_CYCLES`+1 cycles after WAIT entry.
